check_result_collector: RTL and testbench
=========================================

# check_result_collector

Sequential results stage downstream of the nested test modules in the artificial acceptance benches. It takes per-check pass/fail events from the test module under a valid/ready handshake and buffers them in a small FIFO. It drains the FIFO into saturating pass/fail counters and records the ID of the first failing check. When the test ends, it presents a summary with a `done` flag that the wrapping testbench samples.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `ID_W`, default 8: check ID width.
- `CNT_W`, default 16: pass/fail counter width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new collection run (pulse).
- `finish` in 1: end of test; drain and report (pulse).
- `hold` in 1: stalls FIFO pop; models a slow consumer.
- `evt_valid` in 1: check event present.
- `evt_ready` out 1: collector can accept an event.
- `evt_pass` in 1: 1 = check passed, 0 = failed.
- `evt_id` in `ID_W`: check identifier.
- `pass_count` out `CNT_W`: accumulated passes.
- `fail_count` out `CNT_W`: accumulated fails.
- `first_fail_valid` out 1: a fail has been recorded this run.
- `first_fail_id` out `ID_W`: ID of the first failing event popped.
- `busy` out 1: state is RUN or DRAIN.
- `done` out 1: summary valid (state DONE).
- `all_passed` out 1: `done` and `fail_count == 0` and `pass_count != 0`.

## Operation

- State machine with four states.
  - IDLE: wait for `start`.
  - RUN: accept events.
  - DRAIN: no accepts; empty the FIFO.
  - DONE: hold the summary.
- State transitions:
  - IDLE → RUN on `start`. All counters, `first_fail_*` and the FIFO clear on the same edge.
  - RUN → DRAIN on `finish`.
  - DRAIN → DONE when the FIFO is empty and no pop is in flight.
  - DONE → RUN on `start`, with the same clears as IDLE → RUN.
  - `start` in RUN or DRAIN is ignored. `finish` outside RUN is ignored.
- `evt_ready` = (state == RUN) and FIFO not full. It is combinational from registered state and occupancy only, never from `evt_valid`.
- Accept means `evt_valid && evt_ready` on a rising edge. `{evt_pass, evt_id}` is written to the FIFO.
- Pop: one entry per cycle when the FIFO is non-empty and `hold` = 0.
  - A popped pass increments `pass_count`.
  - A popped fail increments `fail_count`.
  - Counters saturate at 2^`CNT_W` − 1 and never wrap.
- The first popped fail of a run sets `first_fail_valid` = 1 and latches `first_fail_id`. Later fails leave `first_fail_id` unchanged.
- FIFO behaviour:
  - Pointers are `log2(DEPTH)+1` bits and wrap naturally.
  - Full means the low bits are equal and the MSBs differ.
  - Simultaneous push and pop keeps the occupancy constant.
  - When the FIFO is full, `evt_ready` = 0 even if a pop occurs in the same cycle. There is no same-cycle bypass.
- Order is preserved: counters reflect events in acceptance order.

## Timing

- Reset values: `evt_ready` = 0, `pass_count` = 0, `fail_count` = 0, `first_fail_valid` = 0, `first_fail_id` = 0, `busy` = 0, `done` = 0, `all_passed` = 0. State is IDLE and the FIFO is empty.
- `rst` asserted mid-run aborts immediately. All state returns to reset values and no `done` is produced.
- Latency with `hold` = 0:
  - Event accepted at edge N is popped at edge N+1.
  - Its counter update is visible after edge N+1, i.e. 1 cycle after acceptance.
- Throughput: one event per cycle sustained with `hold` = 0. The FIFO never fills in that case.
- `finish` and an accepted event on the same edge: the event is accepted and the state moves to DRAIN.
- DRAIN → DONE occurs on the edge after the last pop. `done` is visible in the following cycle.
- `hold` = 1 in DRAIN keeps the state in DRAIN indefinitely.
- Outputs are registered except `evt_ready`, `busy`, `done` and `all_passed`, which are decoded from registered state and counters.

## Test plan

- Reset, then `start`, then 5 pass events back-to-back with `hold` = 0, then `finish` → `pass_count` = 5, `fail_count` = 0, `done` = 1 and `all_passed` = 1 within 3 cycles of `finish`.
- Event sequence pass(1), fail(0x22), pass(3), fail(0x44) → `fail_count` = 2, `pass_count` = 2, `first_fail_id` = 0x22, `all_passed` = 0.
- `hold` = 1 with `DEPTH` = 4 and `evt_valid` held high → exactly 4 accepts, then `evt_ready` = 0. Release `hold` → 4 more accepted in order and all 8 are counted.
- `CNT_W` = 3 with 9 pass events → `pass_count` saturates at 7.
- `finish` while 3 entries are buffered under `hold`, `hold` released 10 cycles later → state stays DRAIN until the drain completes, then `done` = 1 with all 3 counted. `start` during DRAIN has no effect.
- `rst` pulsed mid-RUN with 2 entries buffered → all outputs return to 0 asynchronously. A following `start` and one fail event with ID 7 give `fail_count` = 1 and `first_fail_id` = 7.

Source files
------------

// File: rtl/check_result_collector.sv
// Collects pass/fail check events through a small FIFO into saturating counters and reports a summary.
// Pop latency 1 cycle after accept; evt_ready drops when the FIFO is full or outside RUN.
module check_result_collector #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic             hold,
  input  logic             evt_valid,
  output logic             evt_ready,
  input  logic             evt_pass,
  input  logic [ID_W-1:0]  evt_id,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [ID_W-1:0]  first_fail_id,
  output logic             busy,
  output logic             done,
  output logic             all_passed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [ID_W:0]    r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_ff_vld;
  logic [ID_W-1:0]  r_ff_id;

  logic             w_empty;
  logic             w_full;
  logic             w_clear;
  logic             w_push;
  logic             w_pop;
  logic [ID_W:0]    w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_push  = evt_valid && evt_ready;
  assign w_pop   = !w_empty && !hold;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Ready is decoded from registered state only; a same-cycle pop never frees a slot early.
  assign evt_ready  = (r_state == S_RUN) && !w_full;
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign all_passed = done && (r_fail_cnt == '0) && (r_pass_cnt != '0);

  assign pass_count       = r_pass_cnt;
  assign fail_count       = r_fail_cnt;
  assign first_fail_valid = r_ff_vld;
  assign first_fail_id    = r_ff_id;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {evt_pass, evt_id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_vld   <= 1'b0;
      r_ff_id    <= '0;
    end else if (w_clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_vld   <= 1'b0;
      r_ff_id    <= '0;
    end else if (w_pop) begin
      if (w_head[ID_W]) begin
        if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
      end else begin
        if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
        if (!r_ff_vld) begin
          r_ff_vld <= 1'b1;
          r_ff_id  <= w_head[ID_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start)  r_state <= S_RUN;
        S_RUN:   if (finish) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty) r_state <= S_DONE;
        S_DONE:  if (start)  r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_check_result_collector.sv
// Scoreboard bench for check_result_collector: accepted events are queued and retired against the counters.
module tb_check_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        hold = 1'b0;
  logic        evt_valid = 1'b0;
  logic        evt_pass = 1'b0;
  logic [7:0]  evt_id = '0;
  logic        evt_ready, evt_ready_s;
  logic [15:0] pass_count, fail_count;
  logic [2:0]  pass_count_s, fail_count_s;
  logic        first_fail_valid, first_fail_valid_s;
  logic [7:0]  first_fail_id, first_fail_id_s;
  logic        busy, busy_s, done, done_s, all_passed, all_passed_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  check_result_collector #(.DEPTH(DEPTH), .ID_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .hold(hold),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_pass(evt_pass), .evt_id(evt_id),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_id(first_fail_id),
    .busy(busy), .done(done), .all_passed(all_passed)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  check_result_collector #(.DEPTH(DEPTH), .ID_W(8), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .hold(hold),
    .evt_valid(evt_valid), .evt_ready(evt_ready_s), .evt_pass(evt_pass), .evt_id(evt_id),
    .pass_count(pass_count_s), .fail_count(fail_count_s),
    .first_fail_valid(first_fail_valid_s), .first_fail_id(first_fail_id_s),
    .busy(busy_s), .done(done_s), .all_passed(all_passed_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t    m_state = M_IDLE;
  logic [8:0] q[$];
  int         m_pass = 0;
  int         m_fail = 0;
  bit         m_ffv = 0;
  logic [7:0] m_ffid = '0;

  always @(negedge clk) begin
    logic       acc, pop, clr;
    logic [8:0] e;
    mstate_t    ns;
    if (rst) begin
      m_state = M_IDLE; q.delete();
      m_pass = 0; m_fail = 0; m_ffv = 0; m_ffid = '0;
    end
    chk("evt_ready", evt_ready, (m_state == M_RUN) && (q.size() < DEPTH));
    chk("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
    chk("done", done, m_state == M_DONE);
    chk("pass_count", pass_count, m_pass);
    chk("fail_count", fail_count, m_fail);
    chk("first_fail_valid", first_fail_valid, m_ffv);
    chk("first_fail_id", first_fail_id, m_ffid);
    chk("all_passed", all_passed, (m_state == M_DONE) && (m_fail == 0) && (m_pass != 0));
    if (!rst) begin
      acc = evt_valid && (m_state == M_RUN) && (q.size() < DEPTH);
      pop = (q.size() != 0) && !hold;
      clr = 1'b0;
      ns  = m_state;
      case (m_state)
        M_IDLE:  if (start) begin ns = M_RUN; clr = 1'b1; end
        M_RUN:   if (finish) ns = M_DRAIN;
        M_DRAIN: if (q.size() == 0) ns = M_DONE;
        M_DONE:  if (start) begin ns = M_RUN; clr = 1'b1; end
        default: ns = M_IDLE;
      endcase
      if (pop) begin
        e = q.pop_front();
        if (e[8]) begin
          if (m_pass < 65535) m_pass++;
        end else begin
          if (m_fail < 65535) m_fail++;
          if (!m_ffv) begin m_ffv = 1; m_ffid = e[7:0]; end
        end
      end
      if (acc) q.push_back({evt_pass, evt_id});
      if (clr) begin
        m_pass = 0; m_fail = 0; m_ffv = 0; m_ffid = '0; q.delete();
      end
      m_state = ns;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; tick(); finish = 1'b0;
  endtask

  task automatic send(input logic p, input logic [7:0] id);
    bit ok;
    ok = 1'b0;
    evt_valid = 1'b1; evt_pass = p; evt_id = id;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (evt_ready) begin ok = 1'b1; break; end
    end
    tick();
    evt_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk(tag, ok, 1);
    tick();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_evt_ready", evt_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // 5 passes back to back
    pulse_start();
    for (int i = 0; i < 5; i++) send(1'b1, 8'(i + 1));
    pulse_finish();
    wait_done(3, "t1_done_within_3");
    chk("t1_pass", pass_count, 5);
    chk("t1_fail", fail_count, 0);
    chk("t1_all_passed", all_passed, 1);

    // Mixed sequence
    pulse_start();
    send(1'b1, 8'h01); send(1'b0, 8'h22); send(1'b1, 8'h03); send(1'b0, 8'h44);
    pulse_finish();
    wait_done(10, "t2_done");
    chk("t2_pass", pass_count, 2);
    chk("t2_fail", fail_count, 2);
    chk("t2_first_fail_id", first_fail_id, 8'h22);
    chk("t2_all_passed", all_passed, 0);

    // Fill under hold, then release
    pulse_start();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'(i % 2), 8'(8'h10 + i));
    evt_valid = 1'b1; evt_pass = 1'b0; evt_id = 8'h14;
    repeat (3) begin
      @(negedge clk);
      chk("t3_full_ready", evt_ready, 0);
    end
    tick();
    hold = 1'b0;
    send(1'b0, 8'h14);
    for (int i = 5; i < 8; i++) send(1'b1, 8'(8'h10 + i));
    pulse_finish();
    wait_done(20, "t3_done");
    chk("t3_total", 32'(pass_count) + 32'(fail_count), 8);
    chk("t3_first_fail_id", first_fail_id, 8'h10);

    // Saturation on the 3-bit instance
    pulse_start();
    for (int i = 0; i < 9; i++) send(1'b1, 8'(i));
    pulse_finish();
    wait_done(10, "t4_done");
    chk("t4_sat_pass", pass_count_s, 7);
    chk("t4_wide_pass", pass_count, 9);

    // Drain stalled by hold, start ignored in DRAIN
    pulse_start();
    hold = 1'b1;
    send(1'b1, 8'h31); send(1'b0, 8'h32); send(1'b1, 8'h33);
    pulse_finish();
    repeat (3) tick();
    pulse_start();
    repeat (6) tick();
    @(negedge clk);
    chk("t5_still_drain_busy", busy, 1);
    chk("t5_still_drain_done", done, 0);
    tick();
    hold = 1'b0;
    wait_done(10, "t5_done");
    chk("t5_pass", pass_count, 2);
    chk("t5_fail", fail_count, 1);
    chk("t5_first_fail_id", first_fail_id, 8'h32);

    // Asynchronous reset mid-run
    pulse_start();
    hold = 1'b1;
    send(1'b0, 8'h51); send(1'b1, 8'h52);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", evt_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_pass", pass_count, 0);
    chk("t6_rst_fail", fail_count, 0);
    chk("t6_rst_ffv", first_fail_valid, 0);
    tick();
    rst = 1'b0;
    hold = 1'b0;
    tick();
    pulse_start();
    send(1'b0, 8'h07);
    pulse_finish();
    wait_done(10, "t6_done");
    chk("t6_fail", fail_count, 1);
    chk("t6_first_fail_id", first_fail_id, 8'h07);
    chk("t6_scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
